// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state, opcode, mux-select encodings and instruction classes for multicycle_ctrl
package multicycle_ctrl_pkg;
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_JUMP   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;
  localparam logic [3:0] OP_LI   = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;
  localparam logic [3:0] OP_IN   = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_JMP = 2'b01;
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_IMM = 2'b01;
  localparam logic [1:0] WD_IN  = 2'b10;
  typedef enum logic [2:0] {C_ALU, C_LI, C_IN, C_JMP, C_NT, C_HALT, C_ILL} iclass_t;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: maps opcode and zero to instruction class, post-DECODE state and illegal flag
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output iclass_t        cls,
  output logic [2:0]     next,
  output logic           illegal
);
  logic [3:0] op;
  assign op = opcode[OPW-1 -: 4];
  assign cls = !op[3]        ? C_ALU :
               op == OP_LI   ? C_LI :
               op == OP_IN   ? C_IN :
               op == OP_J    ? C_JMP :
               op == OP_JZ   ? (zero ? C_JMP : C_NT) :
               op == OP_JNZ  ? (zero ? C_NT : C_JMP) :
               op == OP_HALT ? C_HALT : C_ILL;
  assign next = cls == C_ALU                 ? S_EXEC :
                (cls == C_LI || cls == C_IN) ? S_WB :
                cls == C_JMP                 ? S_JUMP :
                cls == C_HALT                ? S_HALT : S_FETCH;
  assign illegal = cls == C_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing the multicycle CPU datapath.
// Define MULTICYCLE_CTRL_STEP_EN to add the step input and single-step WAIT state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            reset,
`ifdef MULTICYCLE_CTRL_STEP_EN
  input  logic            step,
`endif
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  output logic            pc_en,
  output logic [1:0]      pc_sel,
  output logic            ir_en,
  output logic            we3,
  output logic [1:0]      wd_sel,
  output logic [ALUW-1:0] alu_op,
  output logic            flag_ld,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      state
);
  logic [2:0] st, nxt, dec_next, done;
  iclass_t cls, dec_cls;
  logic dec_ill, run;
  multicycle_ctrl_decode #(.OPW(OPW)) u_dec (
    .opcode(opcode),
    .zero(zero),
    .cls(dec_cls),
    .next(dec_next),
    .illegal(dec_ill)
  );
`ifdef MULTICYCLE_CTRL_STEP_EN
  assign done = S_WAIT;
`else
  assign done = S_FETCH;
`endif
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = dec_next == S_FETCH ? done : dec_next;
      S_EXEC:   nxt = S_WB;
      S_WB:     nxt = done;
      S_JUMP:   nxt = done;
      S_HALT:   nxt = S_HALT;
`ifdef MULTICYCLE_CTRL_STEP_EN
      S_WAIT:   nxt = step ? S_FETCH : S_WAIT;
`endif
      default:  nxt = S_FETCH;
    endcase
  end
  // class is captured in DECODE so WB can pick the write-data source
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_FETCH;
      cls <= C_ALU;
    end else begin
      st <= nxt;
      if (st == S_DECODE) cls <= dec_cls;
    end
  end
  assign run = !reset;
  assign pc_en = run && (st == S_FETCH || st == S_JUMP);
  assign pc_sel = run && st == S_JUMP ? PC_JMP : PC_INC;
  assign ir_en = run && st == S_FETCH;
  assign we3 = run && st == S_WB;
  assign wd_sel = !(run && st == S_WB) ? WD_ALU : cls == C_LI ? WD_IMM : cls == C_IN ? WD_IN : WD_ALU;
  assign alu_op = run && (st == S_EXEC || (st == S_WB && cls == C_ALU)) ? ALUW'(opcode[2:0]) : '0;
  assign flag_ld = run && st == S_EXEC;
  assign halted = run && st == S_HALT;
  assign illegal = run && st == S_DECODE && dec_ill;
  assign state = run ? st : S_FETCH;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; stimulus pushes per-cycle expected control words, monitor compares.
module tb_multicycle_ctrl;
  logic clk = 0;
  logic reset, zero, fin;
  logic [3:0] opcode;
  logic pc_en, ir_en, we3, flag_ld, halted, illegal;
  logic [1:0] pc_sel, wd_sel;
  logic [2:0] alu_op, state;
  logic [15:0] got;
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;
`ifdef MULTICYCLE_CTRL_STEP_EN
  logic step = 0;
`endif
  always #5 clk = ~clk;
  multicycle_ctrl dut (
    .clk(clk),
    .reset(reset),
`ifdef MULTICYCLE_CTRL_STEP_EN
    .step(step),
`endif
    .opcode(opcode),
    .zero(zero),
    .pc_en(pc_en),
    .pc_sel(pc_sel),
    .ir_en(ir_en),
    .we3(we3),
    .wd_sel(wd_sel),
    .alu_op(alu_op),
    .flag_ld(flag_ld),
    .halted(halted),
    .illegal(illegal),
    .state(state)
  );
  assign got = {pc_en, pc_sel, ir_en, we3, wd_sel, alu_op, flag_ld, halted, illegal, state};
  function automatic logic [15:0] mk(logic pe, logic [1:0] ps, logic ie, logic w, logic [1:0] wd,
                                     logic [2:0] a, logic f, logic h, logic il, logic [2:0] s);
    return {pe, ps, ie, w, wd, a, f, h, il, s};
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (got !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs got=%h want=0000 t=%0t", got, $time);
      end
    end else if (!fin) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL underflow got=%h want=<nothing> t=%0t", got, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL cycle_outputs got=%h want=%h t=%0t", got, e, $time);
        end
      end
    end
  end
  // one instruction: FETCH, DECODE, then its body cycles, then FETCH again (via WAIT when stepping)
  task automatic run(input logic [3:0] op, input logic z);
    int n;
    logic [2:0] a;
    a = op[2:0];
    n = 0;
    exp_q.push_back(mk(1, 2'b00, 1, 0, 2'b00, 3'd0, 0, 0, 0, 3'd0));
    exp_q.push_back(mk(0, 2'b00, 0, 0, 2'b00, 3'd0, 0, 0, op == 4'hD || op == 4'hE, 3'd1));
    if (!op[3]) begin
      exp_q.push_back(mk(0, 2'b00, 0, 0, 2'b00, a, 1, 0, 0, 3'd2));
      exp_q.push_back(mk(0, 2'b00, 0, 1, 2'b00, a, 0, 0, 0, 3'd3));
      n = 2;
    end else if (op == 4'h8 || op == 4'hC) begin
      exp_q.push_back(mk(0, 2'b00, 0, 1, op == 4'h8 ? 2'b01 : 2'b10, 3'd0, 0, 0, 0, 3'd3));
      n = 1;
    end else if (op == 4'h9 || (op == 4'hA && z) || (op == 4'hB && !z)) begin
      exp_q.push_back(mk(1, 2'b01, 0, 0, 2'b00, 3'd0, 0, 0, 0, 3'd4));
      n = 1;
    end
`ifdef MULTICYCLE_CTRL_STEP_EN
    begin
      int w;
      w = $urandom_range(0, 5);
      if (!op[3]) w = 5;
      for (int i = 0; i <= w; i++) exp_q.push_back(mk(0, 2'b00, 0, 0, 2'b00, 3'd0, 0, 0, 0, 3'd6));
      opcode = 4'($urandom); zero = 1'($urandom); step = 1'($urandom);
      @(posedge clk); #1; opcode = op; zero = z; step = 1'($urandom);
      for (int i = 0; i <= n; i++) begin @(posedge clk); #1; zero = 1'($urandom); step = 1'($urandom); end
      for (int i = 0; i <= w; i++) begin step = (i == w); @(posedge clk); #1; end
      step = 0;
    end
`else
    opcode = 4'($urandom); zero = 1'($urandom);
    @(posedge clk); #1; opcode = op; zero = z;
    for (int i = 0; i <= n; i++) begin @(posedge clk); #1; zero = 1'($urandom); end
`endif
  endtask
  initial begin
    fin = 0;
    reset = 1; opcode = 0; zero = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    run(4'h3, 0);
    run(4'hA, 1);
    run(4'hA, 0);
    run(4'h8, 0);
    run(4'hC, 1);
    run(4'hD, 0);
    run(4'hE, 1);
    run(4'h9, 0);
    run(4'hB, 0);
    run(4'hB, 1);
    repeat (150) run(4'($urandom_range(0, 14)), 1'($urandom));
    exp_q.push_back(mk(1, 2'b00, 1, 0, 2'b00, 3'd0, 0, 0, 0, 3'd0));
    exp_q.push_back(mk(0, 2'b00, 0, 0, 2'b00, 3'd0, 0, 0, 0, 3'd1));
    repeat (20) exp_q.push_back(mk(0, 2'b00, 0, 0, 2'b00, 3'd0, 0, 1, 0, 3'd5));
    @(posedge clk); #1; opcode = 4'hF;
    repeat (21) begin @(posedge clk); #1; opcode = 4'($urandom); zero = 1'($urandom); end
    reset = 1;
    @(posedge clk); #1 reset = 0;
    exp_q.push_back(mk(1, 2'b00, 1, 0, 2'b00, 3'd0, 0, 0, 0, 3'd0));
    exp_q.push_back(mk(0, 2'b00, 0, 0, 2'b00, 3'd0, 0, 0, 0, 3'd1));
    opcode = 4'h5;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    repeat (10) run(4'($urandom_range(0, 14)), 1'($urandom));
    fin = 1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the multicycle CPU datapath: PC register, instruction register, two-read/one-write register file, write-data and PC multiplexers, and the zero-flag flip-flop.
- Takes the decoded opcode and the zero flag, and produces per-cycle enables and selects.
- Sits beside the datapath in the CPU top level; it is the only source of pc_en, ir_en, we3 and flag_ld.

Parameters:
- OPW, 4, opcode width (instruction bits [15:12]).
- ALUW, 3, ALU operation select width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPW  IR opcode field; valid from DECODE onward.
- zero  in  1  zero-flag flip-flop output.
- pc_en  out  1  PC register load enable.
- pc_sel  out  2  PC mux select: 00 = PC+1, 01 = jump target (IR immediate); 10/11 unused, driven 00.
- ir_en  out  1  instruction register load enable.
- we3  out  1  register file write enable.
- wd_sel  out  2  register write-data mux select: 00 = ALU, 01 = immediate, 10 = input port.
- alu_op  out  ALUW  ALU operation.
- flag_ld  out  1  zero-flag load enable (ffd carga).
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset: one clock, synchronous, active-high (name clk / reset). While reset is high, every output is forced to 0. The next state is FETCH.
- Reset asserted mid-instruction: the instruction is abandoned at the next edge, with no write, PC load or flag load.
- States: FETCH, DECODE, EXEC, WB, JUMP, HALT (plus WAIT with the optional feature).
- Outputs depend only on state, except illegal, which depends on DECODE and opcode.
- FETCH: ir_en=1, pc_en=1, pc_sel=00. Next state is DECODE.
- DECODE: all enables are 0. Next state by opcode:
  - 0xxx ALU reg-reg → EXEC.
  - 1000 LI → WB.
  - 1001 J → JUMP.
  - 1010 JZ → JUMP if zero=1, else FETCH.
  - 1011 JNZ → JUMP if zero=0, else FETCH.
  - 1100 IN → WB.
  - 1111 HALT → HALT.
  - 1101/1110 → illegal=1 for that cycle, then FETCH (executes as a NOP).
- zero is sampled in the DECODE cycle only.
- EXEC: alu_op=opcode[2:0], flag_ld=1. Next state is WB.
- WB: we3=1. wd_sel is 00 for ALU, 01 for LI, 10 for IN. During WB, alu_op holds opcode[2:0] for ALU instructions and is 0 otherwise. Next state is FETCH.
- JUMP: pc_en=1, pc_sel=01. Next state is FETCH.
- HALT: halted=1, all enables 0. Only reset exits HALT.
- Latency in cycles, FETCH to next FETCH:
  - ALU: 4.
  - LI / IN: 3.
  - Taken jump: 3.
  - Not-taken branch or illegal opcode: 2.
- pc_en and we3 are never both 1 in the same cycle.
- alu_op is 0 outside EXEC/WB.
- The opcode input is ignored in every state except DECODE, EXEC and WB.

Optional Feature:
- Macro: MULTICYCLE_CTRL_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - Adds state WAIT, entered instead of FETCH after every completed instruction (WB, JUMP, not-taken branch, illegal).
  - WAIT drives all enables to 0 and moves to FETCH on the first cycle with step=1.
  - step in any other state is ignored.
  - Reset still goes directly to FETCH.
- When undefined: no step port, no WAIT state, and behaviour is exactly as above.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state encodings (FETCH=0, DECODE=1, EXEC=2, WB=3, JUMP=4, HALT=5, WAIT=6);
  - opcode constants;
  - pc_sel and wd_sel encodings.
- One sub-module: multicycle_ctrl_decode, purely combinational. It maps opcode and zero to an instruction class, the next-state-after-DECODE, and illegal.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0 during reset. Cycle 1 after release is FETCH with ir_en=pc_en=1 and pc_sel=00.
- opcode=0011 → EXEC with alu_op=011 and flag_ld=1, then WB with we3=1 and wd_sel=00, then FETCH. FETCH-to-FETCH is 4 cycles.
- JZ (1010):
  - zero=1 → JUMP with pc_en=1 and pc_sel=01 (3 cycles).
  - Repeat with zero=0 → back to FETCH after DECODE (2 cycles), and no pc_en in DECODE.
- LI (1000) then IN (1100) → WB with wd_sel=01 then wd_sel=10, we3=1, 3 cycles each.
- Opcode 1101 → illegal pulses exactly 1 cycle and we3 never asserts.
- Opcode 1111 → halted=1 for 20 cycles with no enables. Reset asserted mid-EXEC of a following program → no flag_ld or we3 after the reset edge, and the next state is FETCH.
- With MULTICYCLE_CTRL_STEP_EN:
  - After an ALU instruction the FSM holds WAIT for 5 cycles with step=0.
  - step=1 → FETCH on the next edge.
